cnn_frame_scheduler: RTL and testbench
======================================

Name: cnn_frame_scheduler

Overview:
Sequencing front/back-end for the CNN classifier pipeline. It admits one image frame at a time from a pixel source and generates sop/eop from internal row/column counters. It then blocks further input until the CNN returns its class-score vector, or until a watchdog expires. It serially scans the scores for the arg-max and presents one classification result per frame on a valid/ready interface.

Parameters:
PIX_WIDTH, 16, pixel width of the source stream and the CNN input
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per frame; IMG_WIDTH*IMG_HEIGHT must be >= 2
CLASSES_QNT, 10, number of class scores returned by the CNN
SCORE_WIDTH, 32, width of each class score (signed two's complement)
TIMEOUT_CYCLES, 65536, enabled cycles to wait for a result after eop

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
clk_en  in  1  global clock enable; all state holds while low
s_data  in  PIX_WIDTH  source pixel
s_valid  in  1  source pixel valid
s_ready  out  1  scheduler accepts a pixel this cycle
cnn_data  out  PIX_WIDTH  pixel to CNN
cnn_valid  out  1  pixel valid to CNN
cnn_sop  out  1  first pixel of frame
cnn_eop  out  1  last pixel of frame
cnn_res_valid  in  1  CNN class vector valid (single-cycle pulse)
cnn_classes  in  CLASSES_QNT*SCORE_WIDTH  packed scores; class i at bits [i*SCORE_WIDTH +: SCORE_WIDTH]
res_valid  out  1  classification result valid
res_ready  in  1  result consumer ready
res_class  out  $clog2(CLASSES_QNT)  arg-max index
res_score  out  SCORE_WIDTH  winning score
res_timeout  out  1  result produced by watchdog, not by the CNN
busy  out  1  state != IDLE
frame_cnt  out  16  results handed off; wraps at 65535->0

Behaviour:
- Reset values:
  - state IDLE
  - all outputs 0, except s_ready, which follows its equation
  - internal counters, score register, stale flag cleared
- Reset mid-frame: no eop is emitted and the partial frame is abandoned. The CNN must be reset alongside.
- s_ready = clk_en & (state==IDLE | state==STREAM).
- Pixel accept: s_valid & s_ready.
- cnn_data, cnn_sop and cnn_eop are registered; cnn_valid = valid_reg & clk_en. Latency source->CNN is exactly 1 enabled cycle, and a pixel is never presented twice.
- FSM:
  - IDLE: on accept, forward the pixel with cnn_sop=1, set col=1, row=0, go to STREAM.
  - STREAM: on each accept, forward the pixel and advance col; col wraps at IMG_WIDTH-1 and increments row. The pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1 carries cnn_eop=1; then go to WAIT and clear the timer.
  - WAIT: s_ready=0; the timer increments each enabled cycle.
    - cnn_res_valid with stale=0: capture all scores; best_idx=0, best=score[0], idx=1; go to SCAN.
    - cnn_res_valid with stale=1: discard the vector and clear stale.
    - timer==TIMEOUT_CYCLES-1 and no capture: res_class=0, res_score=0, res_timeout=1, set stale=1, go to OUTPUT.
    - Capture and timeout in the same cycle: capture wins.
  - SCAN: one class per enabled cycle, signed compare. Update best only if score[idx] > best, so ties resolve to the lowest index. After idx=CLASSES_QNT-1, go to OUTPUT. This takes CLASSES_QNT-1 cycles; res_timeout=0.
  - OUTPUT: res_valid=1. res_class, res_score and res_timeout stay stable until res_ready. On the handshake: frame_cnt++, res_valid=0, go to IDLE.
- Stray cnn_res_valid:
  - In IDLE, STREAM, SCAN or OUTPUT it is ignored, unless stale=1, in which case it clears stale. This absorbs a late result after a timeout.
  - A stale result is never reported.
- A next-frame pixel may be accepted in the cycle after the OUTPUT handshake, not in the same cycle.

Test Plan:
- Stream 784 pixels back-to-back (value = index) -> cnn_sop only on pixel 0, cnn_eop only on pixel 783, each one cycle after accept; s_ready=0 from the cycle after pixel 783 is accepted.
- Result vector with score[7]=300 and all others <=100, res_ready=1 -> res_valid 9 cycles after capture, res_class=7, res_score=300, res_timeout=0, frame_cnt=1.
- Scores all -5 except score[3]=score[6]=12 -> res_class=3, res_score=12. All scores equal to -1 -> res_class=0.
- Hold res_ready=0 for 20 cycles -> res_valid and result fields stable, s_ready=0, frame_cnt increments exactly once on release.
- TIMEOUT_CYCLES=64, no result -> res_timeout=1 and res_class=0 exactly 64 cycles after the eop cycle. Then pulse cnn_res_valid (score[2] max) during the next frame's STREAM -> discarded. The next genuine result (score[5] max) reports 5.
- clk_en low 1 of every 3 cycles with s_valid=1 -> exactly 784 cnn_valid pulses, no duplicates. Assert rst at pixel 300 -> all outputs 0; the next frame starts with cnn_sop on its first pixel.

Source files
------------

// File: rtl/cnn_frame_scheduler.sv
// Frame admission and sop/eop framing for the CNN, with a result watchdog, a serial signed
// arg-max over the returned class scores and a valid/ready classification output.
module cnn_frame_scheduler #(
    parameter int PIX_WIDTH      = 16,
    parameter int IMG_WIDTH      = 28,
    parameter int IMG_HEIGHT     = 28,
    parameter int CLASSES_QNT    = 10,
    parameter int SCORE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clk_en,
    input  logic [PIX_WIDTH-1:0]                 s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [PIX_WIDTH-1:0]                 cnn_data,
    output logic                                 cnn_valid,
    output logic                                 cnn_sop,
    output logic                                 cnn_eop,
    input  logic                                 cnn_res_valid,
    input  logic [CLASSES_QNT*SCORE_WIDTH-1:0]   cnn_classes,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [$clog2(CLASSES_QNT)-1:0]       res_class,
    output logic [SCORE_WIDTH-1:0]               res_score,
    output logic                                 res_timeout,
    output logic                                 busy,
    output logic [15:0]                          frame_cnt
);
    localparam int CLS_W = $clog2(CLASSES_QNT);
    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_STREAM, ST_WAIT, ST_SCAN, ST_OUTPUT} state_e;
    typedef logic signed [SCORE_WIDTH-1:0] score_t;

    state_e               state_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [TMR_W-1:0]     timer_q;
    logic                 stale_q;
    score_t               scores_q [CLASSES_QNT];
    logic [CLS_W-1:0]     idx_q;
    logic [CLS_W-1:0]     best_idx_q;
    score_t               best_q;
    logic [PIX_WIDTH-1:0] cnn_data_q;
    logic                 cnn_valid_q;
    logic                 cnn_sop_q;
    logic                 cnn_eop_q;
    logic                 res_valid_q;
    logic [CLS_W-1:0]     res_class_q;
    logic [SCORE_WIDTH-1:0] res_score_q;
    logic                 res_timeout_q;
    logic [15:0]          frame_cnt_q;

    logic                 accept;
    logic [COL_W-1:0]     cur_col;
    logic [ROW_W-1:0]     cur_row;
    logic                 last_col;
    logic                 last_pix;
    logic [COL_W-1:0]     col_d;
    logic [ROW_W-1:0]     row_d;
    score_t               cand;
    logic                 cand_wins;
    score_t               best_d;
    logic [CLS_W-1:0]     best_idx_d;

    assign s_ready = clk_en & (state_q == ST_IDLE || state_q == ST_STREAM);
    assign accept  = s_valid & s_ready;

    // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
    always_comb begin
        // The first pixel of a frame is position (0,0) regardless of leftover counter values.
        cur_col    = (state_q == ST_IDLE) ? '0 : col_q;
        cur_row    = (state_q == ST_IDLE) ? '0 : row_q;
        last_col   = (cur_col == COL_W'(IMG_WIDTH - 1));
        last_pix   = last_col && (cur_row == ROW_W'(IMG_HEIGHT - 1));
        col_d      = last_col ? '0 : cur_col + COL_W'(1);
        row_d      = last_col ? cur_row + ROW_W'(1) : cur_row;
        cand       = scores_q[idx_q];
        cand_wins  = cand > best_q;
        best_d     = cand_wins ? cand : best_q;
        best_idx_d = cand_wins ? idx_q : best_idx_q;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            timer_q       <= '0;
            stale_q       <= 1'b0;
            // NOTE: the score buffer is small and lives in flops, so it is cleared like any register.
            for (int i = 0; i < CLASSES_QNT; i++) scores_q[i] <= '0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_q        <= '0;
            cnn_data_q    <= '0;
            cnn_valid_q   <= 1'b0;
            cnn_sop_q     <= 1'b0;
            cnn_eop_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_class_q   <= '0;
            res_score_q   <= '0;
            res_timeout_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (clk_en) begin
            cnn_valid_q <= 1'b0;
            cnn_sop_q   <= 1'b0;
            cnn_eop_q   <= 1'b0;
            if (cnn_res_valid && stale_q) stale_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_STREAM: begin
                    if (accept) begin
                        cnn_data_q  <= s_data;
                        cnn_valid_q <= 1'b1;
                        cnn_sop_q   <= (state_q == ST_IDLE);
                        cnn_eop_q   <= last_pix;
                        col_q       <= col_d;
                        row_q       <= row_d;
                        state_q     <= last_pix ? ST_WAIT : ST_STREAM;
                        if (last_pix) timer_q <= '0;
                    end
                end
                ST_WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    // A genuine capture beats a watchdog expiry landing in the same cycle.
                    if (cnn_res_valid && !stale_q) begin
                        for (int i = 0; i < CLASSES_QNT; i++)
                            scores_q[i] <= cnn_classes[i*SCORE_WIDTH +: SCORE_WIDTH];
                        best_q     <= cnn_classes[SCORE_WIDTH-1:0];
                        best_idx_q <= '0;
                        idx_q      <= CLS_W'(1);
                        state_q    <= ST_SCAN;
                    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        res_valid_q   <= 1'b1;
                        res_class_q   <= '0;
                        res_score_q   <= '0;
                        res_timeout_q <= 1'b1;
                        stale_q       <= 1'b1;
                        state_q       <= ST_OUTPUT;
                    end
                end
                ST_SCAN: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + CLS_W'(1);
                    if (idx_q == CLS_W'(CLASSES_QNT - 1)) begin
                        res_valid_q   <= 1'b1;
                        res_class_q   <= best_idx_d;
                        res_score_q   <= best_d;
                        res_timeout_q <= 1'b0;
                        state_q       <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cnn_data    = cnn_data_q;
    assign cnn_valid   = cnn_valid_q & clk_en;
    assign cnn_sop     = cnn_sop_q;
    assign cnn_eop     = cnn_eop_q;
    assign res_valid   = res_valid_q;
    assign res_class   = res_class_q;
    assign res_score   = res_score_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Bench for cnn_frame_scheduler: directed frames with randomized pixel gaps and score vectors,
// checked against a plain arg-max reference and frame-position rules.
module tb_cnn_frame_scheduler;
    localparam int PIX  = 16;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int CQ   = 10;
    localparam int SW   = 32;
    localparam int TO   = 64;
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(CQ);

    typedef logic signed [SW-1:0] score_vec_t [CQ];
    typedef struct packed {
        logic [PIX-1:0] data;
        logic           sop;
        logic           eop;
        logic [31:0]    cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst, clk_en, s_valid, s_ready, cnn_valid, cnn_sop, cnn_eop;
    logic cnn_res_valid, res_valid, res_ready, res_timeout, busy;
    logic [PIX-1:0]   s_data, cnn_data;
    logic [CQ*SW-1:0] cnn_classes;
    logic [CW-1:0]    res_class;
    logic [SW-1:0]    res_score;
    logic [15:0]      frame_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_frames = '0;
    logic [31:0] cyc = '0;
    beat_t       beats[$];
    logic [31:0] acc_cyc[$];

    cnn_frame_scheduler #(
        .PIX_WIDTH(PIX), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CLASSES_QNT(CQ),
        .SCORE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cnn_data(cnn_data), .cnn_valid(cnn_valid), .cnn_sop(cnn_sop), .cnn_eop(cnn_eop),
        .cnn_res_valid(cnn_res_valid), .cnn_classes(cnn_classes),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_score(res_score), .res_timeout(res_timeout), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cnn_valid === 1'b1) beats.push_back({cnn_data, cnn_sop, cnn_eop, cyc});

    initial begin
        #3000000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the largest signed score.
    task automatic ref_argmax(input score_vec_t v, output int idx, output logic [SW-1:0] best);
        logic signed [SW-1:0] b;
        idx = 0;
        b = v[0];
        for (int i = 1; i < CQ; i++) if (v[i] > b) begin b = v[i]; idx = i; end
        best = b;
    endtask

    task automatic fill_rand(output score_vec_t v, input int lo, input int span);
        for (int i = 0; i < CQ; i++) v[i] = SW'(lo + int'($urandom_range(span)));
    endtask

    task automatic load_vec(input score_vec_t v);
        for (int i = 0; i < CQ; i++) cnn_classes[i*SW +: SW] = v[i];
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_cnn_valid"}, cnn_valid, 0);
        check({tag, "_cnn_sop"}, cnn_sop, 0);
        check({tag, "_cnn_eop"}, cnn_eop, 0);
        check({tag, "_cnn_data"}, cnn_data, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_class"}, res_class, 0);
        check({tag, "_res_score"}, res_score, 0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_s_ready"}, s_ready, clk_en);
    endtask

    // Offers pixels valued by their index until n_pix are accepted; optional stray result pulse.
    task automatic stream(input int n_pix, input int en_mod, input int vpct, input int stray_at);
        int sent = 0;
        int k = 0;
        bit stray_done = 1'b0;
        beats.delete();
        acc_cyc.delete();
        while (sent < n_pix && k < 20000) begin
            clk_en        = (en_mod == 0) || ((k % en_mod) != en_mod - 1);
            s_valid       = ($urandom_range(99) < vpct);
            s_data        = PIX'(sent);
            cnn_res_valid = (sent == stray_at) && !stray_done && clk_en;
            if (cnn_res_valid) stray_done = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc);
                sent++;
            end
            tick();
            k++;
        end
        s_valid = 1'b0;
        clk_en = 1'b1;
        cnn_res_valid = 1'b0;
        check("stream_done", sent, n_pix);
    endtask

    task automatic post_stream(input string tag, input bit exact);
        int errs = 0;
        @(negedge clk);
        #1;
        check({tag, "_s_ready_low"}, s_ready, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_no_result"}, res_valid, 0);
        check({tag, "_beats"}, beats.size(), NPIX);
        foreach (beats[i]) begin
            if (beats[i].data !== PIX'(i)) errs++;
            if (beats[i].sop !== (i == 0)) errs++;
            if (beats[i].eop !== (i == NPIX - 1)) errs++;
            if (exact && i < acc_cyc.size() && beats[i].cyc != acc_cyc[i] + 1) errs++;
        end
        check({tag, "_beat_errs"}, errs, 0);
        tick();
    endtask

    task automatic send_result(input score_vec_t v, output logic [31:0] pulse_cyc);
        load_vec(v);
        cnn_res_valid = 1'b1;
        @(negedge clk);
        pulse_cyc = cyc;
        tick();
        cnn_res_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp_cls, input logic [SW-1:0] exp_sc,
                                 input bit exp_to, input int exp_delay, input logic [31:0] ref_cyc,
                                 input int hold);
        int n = 0;
        res_ready = (hold == 0);
        @(negedge clk);
        while (res_valid !== 1'b1 && n < 400) begin
            tick();
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        if (exp_delay >= 0) check({tag, "_latency"}, cyc - ref_cyc, exp_delay);
        check({tag, "_class"}, res_class, exp_cls);
        check({tag, "_score"}, res_score, exp_sc);
        check({tag, "_timeout"}, res_timeout, exp_to);
        for (int k = 0; k < hold; k++) begin
            tick();
            @(negedge clk);
            check({tag, "_hold"}, {res_valid, res_class, res_score, res_timeout, s_ready, frame_cnt},
                  {1'b1, CW'(exp_cls), exp_sc, exp_to, 1'b0, exp_frames});
        end
        res_ready = 1'b1;
        tick();
        @(negedge clk);
        exp_frames++;
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        check({tag, "_released"}, res_valid, 0);
        check({tag, "_idle"}, busy, 0);
        tick();
        @(negedge clk);
        check({tag, "_cnt_once"}, frame_cnt, exp_frames);
        tick();
    endtask

    initial begin
        score_vec_t  v;
        int          ecls;
        logic [SW-1:0] esc;
        logic [31:0] pc;
        int          eops;

        rst = 1'b1; clk_en = 1'b1; s_valid = 1'b0; s_data = '0;
        cnn_res_valid = 1'b0; cnn_classes = '0; res_ready = 1'b1;
        check_reset_state("por");
        tick();
        rst = 1'b0;

        // Back-to-back frame, then a clear winner at class 7.
        stream(NPIX, 0, 100, -1);
        post_stream("b2b", 1'b1);
        fill_rand(v, -1000, 1100);
        v[7] = 300;
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        // Capture happens at the edge closing the pulse cycle, then CQ-1 scan cycles.
        expect_result("argmax7", ecls, esc, 1'b0, 1 + (CQ - 1), pc, 0);

        // Tie between classes 3 and 6 resolves low; all-equal resolves to 0.
        stream(NPIX, 0, 70, -1);
        post_stream("tie", 1'b0);
        for (int i = 0; i < CQ; i++) v[i] = -5;
        v[3] = 12; v[6] = 12;
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        expect_result("tie36", ecls, esc, 1'b0, -1, pc, 0);
        stream(NPIX, 0, 70, -1);
        post_stream("eq", 1'b0);
        for (int i = 0; i < CQ; i++) v[i] = -1;
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        expect_result("all_neg1", ecls, esc, 1'b0, -1, pc, 0);

        // Back-pressure on the result for 20 cycles.
        stream(NPIX, 0, 90, -1);
        post_stream("bp", 1'b0);
        fill_rand(v, -50000, 100000);
        ref_argmax(v, ecls, esc);
        res_ready = 1'b0;
        send_result(v, pc);
        expect_result("hold20", ecls, esc, 1'b0, -1, pc, 20);

        // Watchdog expiry, a stale late result during the next frame, then a genuine result.
        stream(NPIX, 0, 100, -1);
        post_stream("wd", 1'b0);
        pc = (beats.size() > 0) ? beats[beats.size()-1].cyc : '0;
        expect_result("timeout", 0, '0, 1'b1, TO, pc, 0);
        fill_rand(v, -100, 200);
        v[2] = 500;
        load_vec(v);
        stream(NPIX, 0, 100, 100);
        post_stream("stray", 1'b0);
        fill_rand(v, -100, 200);
        v[5] = 700;
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        expect_result("after_stale", ecls, esc, 1'b0, -1, pc, 0);

        // Fully random score vectors, wide and narrow (narrow forces ties).
        for (int r = 0; r < 2; r++) begin
            stream(NPIX, 0, 60, -1);
            post_stream("rnd", 1'b0);
            if (r == 0) for (int i = 0; i < CQ; i++) v[i] = $urandom;
            else fill_rand(v, -3, 6);
            ref_argmax(v, ecls, esc);
            send_result(v, pc);
            expect_result("rnd_vec", ecls, esc, 1'b0, 1 + (CQ - 1), pc, 0);
        end

        // Clock enable low one cycle in three.
        stream(NPIX, 3, 100, -1);
        post_stream("gap", 1'b0);
        fill_rand(v, -1000, 2000);
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        expect_result("gap_vec", ecls, esc, 1'b0, -1, pc, 0);

        // Reset mid-frame, then a clean frame.
        stream(300, 3, 100, -1);
        rst = 1'b1;
        check_reset_state("midrst");
        eops = 0;
        foreach (beats[i]) if (beats[i].eop) eops++;
        check("midrst_no_eop", eops, 0);
        tick();
        rst = 1'b0;
        exp_frames = '0;
        stream(NPIX, 0, 100, -1);
        post_stream("after_rst", 1'b1);
        fill_rand(v, -1000, 2000);
        ref_argmax(v, ecls, esc);
        send_result(v, pc);
        expect_result("after_rst_vec", ecls, esc, 1'b0, 1 + (CQ - 1), pc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
